// File: rtl/can_pkg.sv
// Shared CAN message definitions used by the acceptance filter and the receive FIFO.
package can_pkg;

    localparam int CAN_MSG_W = 128;

    typedef logic [CAN_MSG_W-1:0] can_msg_t;

    // Field boundaries inside a stored message; data occupies [63:0]
    localparam int ID_HI  = 127;
    localparam int ID_LO  = 96;
    localparam int DLC_HI = 95;
    localparam int DLC_LO = 64;

endpackage

// File: rtl/can_rx_fifo_mem.sv
// Simple dual-port message store for the receive FIFO: synchronous write, synchronous read.
module can_rx_fifo_mem #(
    parameter  int DEPTH = 64,
    parameter  int MSG_W = 128,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             sys_clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [MSG_W-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [MSG_W-1:0] rd_data
);

    logic [MSG_W-1:0] mem [DEPTH];

    // No reset on the array or the read register so this maps onto block RAM
    always_ff @(posedge sys_clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/can_rx_fifo.sv
// Receive message FIFO behind the CAN acceptance filter, with status and sticky error flags.
// Optional occupancy watermark output enabled by defining CAN_RX_WATERMARK_EN.
module can_rx_fifo
    import can_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int MSG_W = CAN_MSG_W,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             i_sys_clk,
    input  logic             i_reset,
    input  logic             i_rx_w_en,
    input  logic [MSG_W-1:0] i_rx_w_data,
    output logic             o_rx_full,
    input  logic             i_rx_r_en,
    output logic [MSG_W-1:0] o_rx_r_data,
    output logic             o_rx_r_valid,
    output logic             o_rx_empty,
    output logic [CNT_W-1:0] o_rx_count,
    output logic             o_rxok,
    output logic             o_rxofl,
`ifdef CAN_RX_WATERMARK_EN
    input  logic [CNT_W-1:0] i_rx_wm,
    output logic             o_rxfwmemp,
`endif
    input  logic             i_flag_clr,
    output logic             o_rxufl
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count_nxt;
    logic [MSG_W-1:0] mem_rd_data;
    logic             do_wr, do_rd;
    logic             popped_once;

    // Full/empty are registered, so both qualifiers see the pre-cycle state
    assign do_wr = i_rx_w_en && !o_rx_full;
    assign do_rd = i_rx_r_en && !o_rx_empty;

    always_comb begin
        count_nxt = o_rx_count;
        case ({do_wr, do_rd})
            2'b10:   count_nxt = o_rx_count + CNT_W'(1);
            2'b01:   count_nxt = o_rx_count - CNT_W'(1);
            default: count_nxt = o_rx_count;
        endcase
    end

    can_rx_fifo_mem #(
        .DEPTH (DEPTH),
        .MSG_W (MSG_W)
    ) u_mem (
        .sys_clk (i_sys_clk),
        .wr_en   (do_wr),
        .wr_addr (wr_ptr),
        .wr_data (i_rx_w_data),
        .rd_en   (do_rd),
        .rd_addr (rd_ptr),
        .rd_data (mem_rd_data)
    );

    // The RAM read register has no reset; mask it until the first real pop
    assign o_rx_r_data = popped_once ? mem_rd_data : '0;

    always_ff @(posedge i_sys_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            o_rx_count   <= '0;
            o_rx_empty   <= 1'b1;
            o_rx_full    <= 1'b0;
            o_rx_r_valid <= 1'b0;
            o_rxok       <= 1'b0;
            o_rxofl      <= 1'b0;
            o_rxufl      <= 1'b0;
            popped_once  <= 1'b0;
`ifdef CAN_RX_WATERMARK_EN
            o_rxfwmemp   <= 1'b0;
`endif
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_rd) begin
                rd_ptr      <= rd_ptr + PTR_W'(1);
                popped_once <= 1'b1;
            end
            o_rx_count   <= count_nxt;
            o_rx_full    <= (count_nxt == CNT_W'(DEPTH));
            o_rx_empty   <= (count_nxt == '0);
            o_rx_r_valid <= do_rd;
            o_rxok       <= do_wr;
            // Set events take priority over a same-cycle clear
            o_rxofl      <= (i_rx_w_en && o_rx_full)  || (o_rxofl && !i_flag_clr);
            o_rxufl      <= (i_rx_r_en && o_rx_empty) || (o_rxufl && !i_flag_clr);
`ifdef CAN_RX_WATERMARK_EN
            o_rxfwmemp   <= (i_rx_wm != '0) && (count_nxt >= i_rx_wm);
`endif
        end
    end

endmodule

// File: tb/tb_can_rx_fifo.sv
// Randomized scoreboard bench for can_rx_fifo against a queue-based reference model.
module tb_can_rx_fifo;
    import can_pkg::*;

    localparam int DEPTH = 64;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int WM    = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             w_en = 1'b0, r_en = 1'b0, clr = 1'b0;
    can_msg_t         w_data = '0;
    can_msg_t         r_data;
    logic             full, empty, r_valid, rxok, rxofl, rxufl;
    logic [CNT_W-1:0] count;
`ifdef CAN_RX_WATERMARK_EN
    logic [CNT_W-1:0] wm = CNT_W'(WM);
    logic             wm_flag;
`endif

    can_msg_t model[$];
    can_msg_t exp_q[$];
    bit       m_ofl, m_ufl;
    int       errors = 0;
    int       checks = 0;

    can_rx_fifo #(.DEPTH(DEPTH)) dut (
        .i_sys_clk    (clk),
        .i_reset      (rst),
        .i_rx_w_en    (w_en),
        .i_rx_w_data  (w_data),
        .o_rx_full    (full),
        .i_rx_r_en    (r_en),
        .o_rx_r_data  (r_data),
        .o_rx_r_valid (r_valid),
        .o_rx_empty   (empty),
        .o_rx_count   (count),
        .o_rxok       (rxok),
        .o_rxofl      (rxofl),
`ifdef CAN_RX_WATERMARK_EN
        .i_rx_wm      (wm),
        .o_rxfwmemp   (wm_flag),
`endif
        .i_flag_clr   (clr),
        .o_rxufl      (rxufl)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every valid pulse must match the oldest expected pop
    always @(negedge clk) begin
        if (r_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got %0h expected no pop at %0t", r_data, $time);
            end else begin
                chk("pop_data", r_data, exp_q.pop_front());
            end
        end
    end

    task automatic check_status(input bit exp_ok, input bit exp_vld);
        chk("count", 128'(count), 128'(model.size()));
        chk("empty", 128'(empty), 128'(model.size() == 0));
        chk("full",  128'(full),  128'(model.size() == DEPTH));
        chk("rxok",  128'(rxok),  128'(exp_ok));
        chk("valid", 128'(r_valid), 128'(exp_vld));
        chk("rxofl", 128'(rxofl), 128'(m_ofl));
        chk("rxufl", 128'(rxufl), 128'(m_ufl));
`ifdef CAN_RX_WATERMARK_EN
        chk("wm", 128'(wm_flag), 128'(model.size() >= WM));
`endif
    endtask

    task automatic step(input bit w, input can_msg_t d, input bit r, input bit c);
        int sz;
        bit wok, rok;
        @(negedge clk);
        w_en = w; w_data = d; r_en = r; clr = c;
        @(posedge clk);
        sz  = model.size();
        wok = w && (sz < DEPTH);
        rok = r && (sz > 0);
        if (rok) exp_q.push_back(model.pop_front());
        if (wok) model.push_back(d);
        m_ofl = (w && sz == DEPTH) || (m_ofl && !c);
        m_ufl = (r && sz == 0)     || (m_ufl && !c);
        #1;
        check_status(wok, rok);
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0);
    endtask

    function automatic can_msg_t rnd_msg();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_reset_state();
        chk("rst_count", 128'(count), 128'(0));
        chk("rst_empty", 128'(empty), 128'(1));
        chk("rst_full",  128'(full),  128'(0));
        chk("rst_data",  r_data,      128'(0));
        chk("rst_valid", 128'(r_valid), 128'(0));
        chk("rst_rxok",  128'(rxok),  128'(0));
        chk("rst_ofl",   128'(rxofl), 128'(0));
        chk("rst_ufl",   128'(rxufl), 128'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model.delete();
        m_ofl = 1'b0;
        m_ufl = 1'b0;
        check_reset_state();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #12;
        check_reset_state();
        @(negedge clk);
        rst = 1'b0;

        // Three messages in, three out, in order
        step(1'b1, {4{32'hAAAA_0001}}, 1'b0, 1'b0);
        step(1'b1, {4{32'hBBBB_0002}}, 1'b0, 1'b0);
        step(1'b1, {4{32'hCCCC_0003}}, 1'b0, 1'b0);
        repeat (3) step(1'b0, '0, 1'b1, 1'b0);
        idle();

        // Fill to DEPTH, overflow once, pop the first, clear the flag
        repeat (DEPTH) step(1'b1, rnd_msg(), 1'b0, 1'b0);
        step(1'b1, rnd_msg(), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);

        // Refill, then write+read while full: read wins, write dropped
        step(1'b1, rnd_msg(), 1'b0, 1'b0);
        step(1'b1, rnd_msg(), 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);

        // Drain to 5, then write+read keeps count steady
        repeat (DEPTH - 1 - 5) step(1'b0, '0, 1'b1, 1'b0);
        repeat (3) step(1'b1, rnd_msg(), 1'b1, 1'b0);
        repeat (5) step(1'b0, '0, 1'b1, 1'b0);

        // Underflow, then a clear colliding with another underflow
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        // Write+read on empty: write lands, read is an underflow
        step(1'b1, rnd_msg(), 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);

        // Random interleaving with a reset in the middle
        for (int i = 0; i < 100; i++) begin
            if (i == 60) begin
                do_reset();
                step(1'b0, '0, 1'b1, 1'b0);
            end
            step($urandom_range(0, 3) != 0, rnd_msg(), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 9) == 0);
            repeat ($urandom_range(0, 2)) idle();
        end
        while (model.size() != 0) step(1'b0, '0, 1'b1, 1'b0);
        idle();
        idle();
        chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
